// File: rtl/keypad_pkg.sv
// Shared types, opcode constants and the key-map decode for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESS,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_OP,
        KC_ENTER,
        KC_RESULT
    } key_class_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_code_t;

    typedef struct packed {
        key_class_t cls;
        logic [3:0] value;
    } key_info_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DET = 3'b011;

    // Layout: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
    function automatic key_info_t key_decode(input key_code_t code);
        key_info_t info;
        info.cls   = KC_DIGIT;
        info.value = 4'd0;
        if (code.col == 2'd3) begin
            info.cls = KC_OP;
            unique case (code.row)
                2'd0:    info.value = {1'b0, OP_ADD};
                2'd1:    info.value = {1'b0, OP_SUB};
                2'd2:    info.value = {1'b0, OP_MUL};
                default: info.value = {1'b0, OP_DET};
            endcase
        end else if (code.row == 2'd3) begin
            unique case (code.col)
                2'd0:    info.cls = KC_ENTER;
                2'd1:    info.cls = KC_DIGIT;
                default: info.cls = KC_RESULT;
            endcase
        end else begin
            info.value = 4'(code.row) * 4'd3 + 4'(code.col) + 4'd1;
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_decoder_sync2.sv
// Parameterised two-flop synchroniser; resets to all-ones (idle level of active-low inputs).
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 keypad scanner: row ring, column debounce and decode into one-cycle key event flags.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [3:0] row_drive,
    input  logic [3:0] col_sense,
    output logic [3:0] digit,
    output logic [2:0] opcode,
    output logic       key_strobe,
    output logic       is_dig,
    output logic       is_op,
    output logic       is_enter,
    output logic       is_result
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    logic [3:0]       col_sync;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_code_t        cand_q, cand_d;
    logic [3:0]       row_drive_d, digit_d;
    logic [2:0]       opcode_d;
    logic             strobe_d, dig_d, op_d, enter_d, result_d;
    logic             sample_c, any_low_c;
    logic [1:0]       col_idx_c;
    key_code_t        sample_code_c;
    key_info_t        info_c;

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (col_sense),
        .q    (col_sync)
    );

    // Lowest-index low column wins when several are pressed together.
    always_comb begin
        sample_c  = (dwell_q == DIV_LAST);
        any_low_c = ~&col_sync;
        if (!col_sync[0])      col_idx_c = 2'd0;
        else if (!col_sync[1]) col_idx_c = 2'd1;
        else if (!col_sync[2]) col_idx_c = 2'd2;
        else                   col_idx_c = 2'd3;
        sample_code_c.row = row_q;
        sample_code_c.col = col_idx_c;
        info_c            = key_decode(cand_q);
        dwell_d           = sample_c ? '0 : dwell_q + DIV_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        digit_d  = digit;
        opcode_d = opcode;
        strobe_d = 1'b0;
        dig_d    = 1'b0;
        enter_d  = 1'b0;
        result_d = 1'b0;
        op_d     = is_op & ~(is_enter | is_result);

        unique case (state_q)
            ST_SCAN: begin
                if (sample_c) begin
                    if (any_low_c) begin
                        state_d = ST_DEBOUNCE;
                        cand_d  = sample_code_c;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (sample_c) begin
                    if (!any_low_c) begin
                        state_d = ST_SCAN;
                        row_d   = row_q + 2'd1;
                        cnt_d   = '0;
                    end else if (sample_code_c == cand_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            state_d = ST_PRESS;
                        end
                    end else begin
                        cand_d = sample_code_c;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            ST_PRESS: begin
                state_d  = ST_HELD;
                cnt_d    = '0;
                strobe_d = 1'b1;
                unique case (info_c.cls)
                    KC_DIGIT: begin
                        dig_d   = 1'b1;
                        digit_d = info_c.value;
                    end
                    KC_OP: begin
                        opcode_d = info_c.value[2:0];
                        op_d     = 1'b1;
                    end
                    KC_ENTER:  enter_d  = 1'b1;
                    default:   result_d = 1'b1;
                endcase
            end
            default: begin
                // Wait for DEBOUNCE consecutive all-high samples before re-arming.
                if (sample_c) begin
                    if (any_low_c) begin
                        cnt_d = '0;
                    end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                        state_d = ST_SCAN;
                        row_d   = row_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        row_drive_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dwell_q    <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            row_drive  <= 4'b1110;
            digit      <= '0;
            opcode     <= OP_ADD;
            key_strobe <= 1'b0;
            is_dig     <= 1'b0;
            is_op      <= 1'b0;
            is_enter   <= 1'b0;
            is_result  <= 1'b0;
        end else begin
            dwell_q    <= dwell_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            row_drive  <= row_drive_d;
            digit      <= digit_d;
            opcode     <= opcode_d;
            key_strobe <= strobe_d;
            is_dig     <= dig_d;
            is_op      <= op_d;
            is_enter   <= enter_d;
            is_result  <= result_d;
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Randomised keypad presses against a key-level reference model of the decoder's events.
module tb_keypad_decoder;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int LAT_MAX = (4 + DEBOUNCE) * SCAN_DIV + 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] row_drive, col_sense, digit;
    logic [2:0] opcode;
    logic       key_strobe, is_dig, is_op, is_enter, is_result;

    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          orphan = 0;
    bit          pend = 0;

    typedef struct {
        int         cyc;
        logic       dig;
        logic       ent;
        logic       res;
        logic [3:0] digit;
        logic [2:0] opcode;
        logic       is_op;
    } ev_t;

    ev_t  ev_q[$];
    logic op_next_q[$];

    logic [3:0] exp_digit  = '0;
    logic [2:0] exp_opcode = '0;
    logic       exp_is_op  = 1'b0;
    string      keymap     = "123A456B789C*0#D";

    keypad_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .row_drive  (row_drive),
        .col_sense  (col_sense),
        .digit      (digit),
        .opcode     (opcode),
        .key_strobe (key_strobe),
        .is_dig     (is_dig),
        .is_op      (is_op),
        .is_enter   (is_enter),
        .is_result  (is_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical matrix: a pressed key shorts its column low while its row is driven.
    always_comb begin
        col_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_drive[r] && pressed[r*4+c]) col_sense[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (pend) begin
            op_next_q.push_back(is_op);
            pend = 0;
        end
        if (key_strobe) begin
            ev_q.push_back('{cyc: cyc, dig: is_dig, ent: is_enter, res: is_result,
                             digit: digit, opcode: opcode, is_op: is_op});
            pend = 1;
        end
        if (!key_strobe && (is_dig || is_enter || is_result)) orphan++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] next_row(input logic [3:0] cur);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (!cur[i]) idx = i;
        return ~(4'b0001 << ((idx + 1) % 4));
    endfunction

    // Update the model for key k and compare against the event logged since n0.
    task automatic verify(input int n0, input int k, input int t_lo, input int t_hi);
        byte   ch;
        string nm;
        logic  e_dig, e_ent, e_res, e_after;
        ch    = keymap.getc(k);
        nm    = $sformatf("%c", ch);
        e_dig = (ch >= "0" && ch <= "9");
        e_ent = (ch == "*");
        e_res = (ch == "#");
        if (e_dig) exp_digit = 4'(ch - "0");
        if (ch >= "A" && ch <= "D") begin
            exp_opcode = 3'(ch - "A");
            exp_is_op  = 1'b1;
        end
        e_after = exp_is_op & ~(e_ent | e_res);
        check({"strobes_", nm}, ev_q.size() - n0, 1);
        if (ev_q.size() > n0) begin
            check({"latency_", nm}, (ev_q[n0].cyc > t_lo && ev_q[n0].cyc <= t_hi), 1);
            check({"is_dig_", nm}, ev_q[n0].dig, e_dig);
            check({"is_enter_", nm}, ev_q[n0].ent, e_ent);
            check({"is_result_", nm}, ev_q[n0].res, e_res);
            check({"digit_", nm}, ev_q[n0].digit, exp_digit);
            check({"opcode_", nm}, ev_q[n0].opcode, exp_opcode);
            check({"is_op_", nm}, ev_q[n0].is_op, exp_is_op);
            if (op_next_q.size() > n0) check({"is_op_next_", nm}, op_next_q[n0], e_after);
        end
        exp_is_op = e_after;
    endtask

    task automatic press(input logic [15:0] keys, input bit bounce, input int hold);
        int n0, k, t_stable;
        n0 = ev_q.size();
        k  = 0;
        for (int i = 15; i >= 0; i--) if (keys[i]) k = i;
        @(negedge clk);
        if (bounce) begin
            for (int t = 0; t < 20; t++) begin
                pressed = ((t / 3) % 2 == 0) ? keys : 16'h0;
                @(negedge clk);
            end
        end
        pressed  = keys;
        t_stable = cyc;
        repeat (hold) @(negedge clk);
        pressed = '0;
        repeat (48) @(negedge clk);
        verify(n0, k, t_stable, t_stable + LAT_MAX);
    endtask

    initial begin
        logic [3:0] prev;
        int         last_chg, n_chg, n0, t_rel;
        bit         found;

        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row_drive", row_drive, 4'b1110);
        check("rst_digit", digit, 4'd0);
        check("rst_opcode", opcode, 3'd0);
        check("rst_flags", {key_strobe, is_dig, is_op, is_enter, is_result}, 5'd0);
        nrst = 1'b1;

        // Idle scan: one-cold rotation, SCAN_DIV cycles per row, no events.
        n0 = ev_q.size();
        prev = row_drive;
        last_chg = -1;
        n_chg = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (row_drive !== prev) begin
                check("row_next", row_drive, next_row(prev));
                if (last_chg >= 0) check("row_dwell", cyc - last_chg, SCAN_DIV);
                last_chg = cyc;
                prev = row_drive;
                n_chg++;
            end
        end
        check("row_changes", (n_chg >= 200 / SCAN_DIV - 1), 1);
        check("idle_strobes", ev_q.size() - n0, 0);

        press(16'h0100, 0, 100);               // '7' held long
        press(16'h0010, 1, 60);                // '4' with bounce
        press(16'h0800, 0, 50);                // 'C'
        press(16'h4000, 0, 50);                // '#'
        press(16'h0060, 0, 50);                // '5' and '6' together

        for (int i = 0; i < 12; i++) begin
            press(16'(1) << $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  int'($urandom_range(40, 100)));
        end

        // Reset while '3' is mid-debounce, keep holding it.
        pressed = '0;
        repeat (40) @(negedge clk);
        found = 0;
        prev = row_drive;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (row_drive == 4'b1110 && prev != 4'b1110) found = 1;
            prev = row_drive;
        end
        check("rst_row0_seen", found, 1);
        n0 = ev_q.size();
        pressed = 16'h0004;
        repeat (6) @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_digit", digit, 4'd0);
        check("mid_rst_opcode", opcode, 3'd0);
        check("mid_rst_flags", {key_strobe, is_dig, is_op, is_enter, is_result}, 5'd0);
        exp_digit  = '0;
        exp_opcode = '0;
        exp_is_op  = 1'b0;
        nrst  = 1'b1;
        t_rel = cyc;
        repeat (60) @(negedge clk);
        verify(n0, 2, t_rel + DEBOUNCE * SCAN_DIV - 1, t_rel + LAT_MAX);
        pressed = '0;
        repeat (40) @(negedge clk);

        check("orphan_flags", orphan, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
